// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: memory op encoding,
// arbiter state and port identifiers.
package mem_port_arbiter_pkg;

   typedef enum logic [2:0] {
      MEM_B  = 3'd0,
      MEM_H  = 3'd1,
      MEM_W  = 3'd2,
      MEM_BU = 3'd4,
      MEM_HU = 3'd5
   } mem_op_t;

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

   typedef enum logic {PORT_IF, PORT_D} arb_port_t;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Grant selection: masks requests whose done is showing, prefers the data
// port and forces a fetch grant once the data port has won too often.
module mem_arb_pick
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic      clk,
   input  logic      resetn,
   input  logic      arb_idle,
   input  logic      if_req,
   input  logic      d_req,
   input  logic      if_done,
   input  logic      d_done,
   output logic      grant_valid_c,
   output arb_port_t grant_port_c
);

   localparam int unsigned CW = cnt_width(STARVE_LIMIT);

   logic [CW-1:0] starve_q, starve_d;
   logic          if_elig, d_elig, force_if;

   always_comb begin
      if_elig       = arb_idle & if_req & ~if_done;
      d_elig        = arb_idle & d_req & ~d_done;
      force_if      = (starve_q == CW'(STARVE_LIMIT));
      grant_valid_c = if_elig | d_elig;
      grant_port_c  = (d_elig & ~(if_elig & force_if)) ? PORT_D : PORT_IF;

      // Counts data wins while fetch waits; saturates at the limit.
      starve_d = starve_q;
      if (!if_req) begin
         starve_d = '0;
      end else if (grant_valid_c && grant_port_c == PORT_IF) begin
         starve_d = '0;
      end else if (grant_valid_c && !force_if) begin
         starve_d = starve_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) starve_q <= '0;
      else         starve_q <= starve_d;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency data_memory between the fetch and load/store
// ports; one access in flight, done pulse and held read data per port.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned MEM_LATENCY  = 1,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned XLEN         = 32
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            if_req,
   input  logic [XLEN-1:0] if_addr,
   output logic [XLEN-1:0] if_rdata,
   output logic            if_done,
   output logic            if_stall,
   input  logic            d_req,
   input  logic            d_wr_en,
   input  mem_op_t         d_op,
   input  logic [XLEN-1:0] d_addr,
   input  logic [XLEN-1:0] d_wdata,
   output logic [XLEN-1:0] d_rdata,
   output logic            d_done,
   output logic            d_stall,
   output logic            mem_wr_en,
   output mem_op_t         mem_op,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_data_in,
   input  logic [XLEN-1:0] mem_data_out
);

   if (MEM_LATENCY < 1) begin : g_bad_latency
      $error("MEM_LATENCY must be >= 1");
   end

   localparam int unsigned LW = cnt_width(MEM_LATENCY);

   arb_state_t      state_q, state_d;
   arb_port_t       port_q, port_d;
   logic            wr_q, wr_d;
   mem_op_t         op_q, op_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [LW-1:0]   lat_q, lat_d;
   logic            strobe_q, strobe_d;
   logic            if_done_q, if_done_d;
   logic            d_done_q, d_done_d;
   logic [XLEN-1:0] if_rdata_q, if_rdata_d;
   logic [XLEN-1:0] d_rdata_q, d_rdata_d;
   logic            grant_valid;
   arb_port_t       grant_port;

   mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
      .clk           (clk),
      .resetn        (resetn),
      .arb_idle      (state_q == ARB_IDLE),
      .if_req        (if_req),
      .d_req         (d_req),
      .if_done       (if_done_q),
      .d_done        (d_done_q),
      .grant_valid_c (grant_valid),
      .grant_port_c  (grant_port)
   );

   // Next state: sample winner at grant, count latency, strobe and capture at the end.
   always_comb begin
      state_d    = state_q;
      port_d     = port_q;
      wr_d       = wr_q;
      op_d       = op_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      lat_d      = lat_q;
      strobe_d   = 1'b0;
      if_done_d  = 1'b0;
      d_done_d   = 1'b0;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      case (state_q)
         ARB_IDLE: begin
            if (grant_valid) begin
               state_d = ARB_BUSY;
               port_d  = grant_port;
               lat_d   = LW'(MEM_LATENCY - 1);
               if (grant_port == PORT_D) begin
                  addr_d   = d_addr;
                  op_d     = d_op;
                  wr_d     = d_wr_en;
                  wdata_d  = d_wdata;
                  strobe_d = d_wr_en && (MEM_LATENCY == 1);
               end else begin
                  addr_d = if_addr;
                  op_d   = MEM_W;
                  wr_d   = 1'b0;
               end
            end
         end
         ARB_BUSY: begin
            if (lat_q == '0) begin
               state_d = ARB_IDLE;
               if (port_q == PORT_IF) begin
                  if_done_d  = 1'b1;
                  if_rdata_d = mem_data_out;
               end else begin
                  d_done_d = 1'b1;
                  if (!wr_q) d_rdata_d = mem_data_out;
               end
            end else begin
               lat_d    = lat_q - LW'(1);
               strobe_d = wr_q && (lat_q == LW'(1));
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ARB_IDLE;
         port_q     <= PORT_IF;
         wr_q       <= 1'b0;
         op_q       <= MEM_W;
         addr_q     <= '0;
         wdata_q    <= '0;
         lat_q      <= '0;
         strobe_q   <= 1'b0;
         if_done_q  <= 1'b0;
         d_done_q   <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         port_q     <= port_d;
         wr_q       <= wr_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         lat_q      <= lat_d;
         strobe_q   <= strobe_d;
         if_done_q  <= if_done_d;
         d_done_q   <= d_done_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   assign mem_wr_en   = strobe_q;
   assign mem_op      = op_q;
   assign mem_addr    = addr_q;
   assign mem_data_in = wdata_q;
   assign if_done     = if_done_q;
   assign d_done      = d_done_q;
   assign if_rdata    = if_rdata_q;
   assign d_rdata     = d_rdata_q;
   assign if_stall    = if_req & ~if_done_q;
   assign d_stall     = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (latency 1 and 3), each with a
// word memory, a timeline-based reference model and a per-cycle comparator.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned STARVE = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [1:0]        rstn;
   logic [1:0]        if_req, if_done, if_stall;
   logic [1:0][31:0]  if_addr, if_rdata;
   logic [1:0]        d_req, d_wr_en, d_done, d_stall;
   mem_op_t [1:0]     d_op;
   logic [1:0][31:0]  d_addr, d_wdata, d_rdata;
   logic [1:0]        mem_wr_en;
   mem_op_t [1:0]     mem_op;
   logic [1:0][31:0]  mem_addr, mem_data_in, mem_data_out;

   function automatic logic [31:0] init_word(input int unsigned idx);
      return (idx == 64) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(idx);
   endfunction

   function automatic mem_op_t pick_op(input int unsigned sel);
      case (sel)
         0:       return MEM_B;
         1:       return MEM_H;
         2:       return MEM_BU;
         3:       return MEM_HU;
         default: return MEM_W;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic cyc_step();
      @(posedge clk);
      #2;
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int unsigned LAT = (g == 0) ? 1 : 3;

      logic        rstn_l;
      logic [31:0] tbmem [256];
      bit   [255:0] tbvalid;
      logic [31:0] smem [256];

      assign rstn_l = rstn[g];
      assign mem_data_out[g] = tbvalid[mem_addr[g][9:2]] ? tbmem[mem_addr[g][9:2]]
                                                         : init_word(32'(mem_addr[g][9:2]));

      always @(posedge clk) begin
         if (mem_wr_en[g]) begin
            tbmem[mem_addr[g][9:2]]   <= mem_data_in[g];
            tbvalid[mem_addr[g][9:2]] <= 1'b1;
         end
      end

      mem_port_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(STARVE), .XLEN(XLEN)) u_dut (
         .clk          (clk),
         .resetn       (rstn[g]),
         .if_req       (if_req[g]),
         .if_addr      (if_addr[g]),
         .if_rdata     (if_rdata[g]),
         .if_done      (if_done[g]),
         .if_stall     (if_stall[g]),
         .d_req        (d_req[g]),
         .d_wr_en      (d_wr_en[g]),
         .d_op         (d_op[g]),
         .d_addr       (d_addr[g]),
         .d_wdata      (d_wdata[g]),
         .d_rdata      (d_rdata[g]),
         .d_done       (d_done[g]),
         .d_stall      (d_stall[g]),
         .mem_wr_en    (mem_wr_en[g]),
         .mem_op       (mem_op[g]),
         .mem_addr     (mem_addr[g]),
         .mem_data_in  (mem_data_in[g]),
         .mem_data_out (mem_data_out[g])
      );

      // Model: each access is a grant cycle g0; busy g0+1..g0+LAT, done at g0+LAT+1.
      int          cyc, g0, starve;
      bit          act, pd, wr, busy, dn_if, dn_d, ie, de, take_if;
      logic [31:0] addr, wdata, e_if_rd, e_d_rd, e_addr, e_din;
      mem_op_t     op, e_op;
      bit          e_if_done, e_d_done, e_wr;

      task automatic model_reset();
         act = 0; cyc = 0; g0 = 0; starve = 0; pd = 0; wr = 0;
         addr = '0; wdata = '0; op = MEM_W;
         e_if_rd = '0; e_d_rd = '0; e_addr = '0; e_din = '0; e_op = MEM_W;
         e_if_done = 0; e_d_done = 0; e_wr = 0;
      endtask

      initial begin
         for (int i = 0; i < 256; i++) smem[i] = init_word(32'(i));
         model_reset();
         forever begin
            @(posedge clk or negedge rstn_l);
            if (!rstn_l) begin
               model_reset();
            end else begin
               busy  = act && cyc > g0 && cyc <= g0 + int'(LAT);
               dn_if = act && !pd && cyc == g0 + int'(LAT) + 1;
               dn_d  = act && pd && cyc == g0 + int'(LAT) + 1;
               if (busy && cyc == g0 + int'(LAT)) begin
                  if (wr)      smem[addr[9:2]] = wdata;
                  else if (pd) e_d_rd = smem[addr[9:2]];
                  else         e_if_rd = smem[addr[9:2]];
               end
               if (!busy) begin
                  ie = if_req[g] && !dn_if;
                  de = d_req[g] && !dn_d;
                  if (ie || de) begin
                     take_if = ie && (!de || starve >= int'(STARVE));
                     act = 1; g0 = cyc; pd = !take_if;
                     if (take_if) begin
                        addr = if_addr[g]; op = MEM_W; wr = 0;
                     end else begin
                        addr = d_addr[g]; op = d_op[g]; wr = d_wr_en[g]; wdata = d_wdata[g];
                     end
                     if (if_req[g]) starve = take_if ? 0 : starve + 1;
                  end
               end
               if (!if_req[g]) starve = 0;
               cyc++;
               e_wr      = act && wr && cyc == g0 + int'(LAT);
               e_if_done = act && !pd && cyc == g0 + int'(LAT) + 1;
               e_d_done  = act && pd && cyc == g0 + int'(LAT) + 1;
               e_addr    = addr;
               e_op      = op;
               e_din     = wdata;
            end
         end
      end

      initial begin
         @(posedge clk);
         forever begin
            @(negedge clk);
            chk($sformatf("L%0d if_done", LAT),   32'(if_done[g]),   32'(e_if_done));
            chk($sformatf("L%0d d_done", LAT),    32'(d_done[g]),    32'(e_d_done));
            chk($sformatf("L%0d mem_wr_en", LAT), 32'(mem_wr_en[g]), 32'(e_wr));
            chk($sformatf("L%0d mem_addr", LAT),  mem_addr[g],       e_addr);
            chk($sformatf("L%0d mem_op", LAT),    32'(mem_op[g]),    32'(e_op));
            chk($sformatf("L%0d if_rdata", LAT),  if_rdata[g],       e_if_rd);
            chk($sformatf("L%0d d_rdata", LAT),   d_rdata[g],        e_d_rd);
            chk($sformatf("L%0d if_stall", LAT),  32'(if_stall[g]),  32'(if_req[g] & ~e_if_done));
            chk($sformatf("L%0d d_stall", LAT),   32'(d_stall[g]),   32'(d_req[g] & ~e_d_done));
            if (e_wr || !rstn_l)
               chk($sformatf("L%0d mem_data_in", LAT), mem_data_in[g], e_din);
         end
      end
   end

   task automatic directed_l1();
      cyc_step();
      d_req[0] = 1'b1; d_wr_en[0] = 1'b0; d_op[0] = MEM_W; d_addr[0] = 32'h100;
      #2 chk("t1 d_stall c0", 32'(d_stall[0]), 32'd1);
      cyc_step(); #2;
      chk("t1 mem_addr c1", mem_addr[0], 32'h100);
      chk("t1 d_stall c1", 32'(d_stall[0]), 32'd1);
      cyc_step(); #2;
      chk("t1 d_done c2", 32'(d_done[0]), 32'd1);
      chk("t1 d_rdata c2", d_rdata[0], 32'hDEADBEEF);
      chk("t1 d_stall c2", 32'(d_stall[0]), 32'd0);
      cyc_step(); d_req[0] = 1'b0;
      #2 chk("t5 d_done c3", 32'(d_done[0]), 32'd0);
      cyc_step();
      #2 chk("t5 no regrant c4", 32'(d_done[0]), 32'd0);
      cyc_step();
      if_req[0] = 1'b1; if_addr[0] = 32'h200; d_req[0] = 1'b1; d_addr[0] = 32'h104;
      cyc_step();
      #2 chk("t3 data first c1", mem_addr[0], 32'h104);
      cyc_step(); #2;
      chk("t3 d_done c2", 32'(d_done[0]), 32'd1);
      chk("t3 if_done c2", 32'(if_done[0]), 32'd0);
      chk("t3 d_rdata c2", d_rdata[0], 32'h1000_0041);
      cyc_step(); d_req[0] = 1'b0; #2;
      chk("t3 fetch no bubble c3", mem_addr[0], 32'h200);
      chk("t3 if_stall c3", 32'(if_stall[0]), 32'd1);
      cyc_step(); #2;
      chk("t3 if_done c4", 32'(if_done[0]), 32'd1);
      chk("t3 if_rdata c4", if_rdata[0], 32'h1000_0080);
      cyc_step(); if_req[0] = 1'b0;
   endtask

   task automatic directed_l3();
      cyc_step();
      d_req[1] = 1'b1; d_wr_en[1] = 1'b1; d_op[1] = MEM_W;
      d_addr[1] = 32'h40; d_wdata[1] = 32'h12345678;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) cyc_step();
         #2;
         chk($sformatf("t2 mem_wr_en c%0d", c), 32'(mem_wr_en[1]), 32'(c == 3));
         chk($sformatf("t2 d_done c%0d", c),    32'(d_done[1]),    32'(c == 4));
      end
      d_req[1] = 1'b0;
      cyc_step();
      d_req[1] = 1'b1; d_wr_en[1] = 1'b0;
      repeat (4) cyc_step();
      #2;
      chk("t2 readback done", 32'(d_done[1]), 32'd1);
      chk("t2 readback data", d_rdata[1], 32'h12345678);
      d_req[1] = 1'b0;
      cyc_step();
      d_req[1] = 1'b1; d_wr_en[1] = 1'b1; d_addr[1] = 32'h80; d_wdata[1] = 32'hCAFEF00D;
      cyc_step(); cyc_step();
      rstn[1] = 1'b0; d_req[1] = 1'b0; #2;
      chk("t6 rst mem_wr_en", 32'(mem_wr_en[1]), 32'd0);
      chk("t6 rst d_done", 32'(d_done[1]), 32'd0);
      chk("t6 rst d_rdata", d_rdata[1], 32'd0);
      chk("t6 rst mem_addr", mem_addr[1], 32'd0);
      chk("t6 rst mem_data_in", mem_data_in[1], 32'd0);
      chk("t6 rst mem_op", 32'(mem_op[1]), 32'(MEM_W));
      repeat (2) begin
         cyc_step(); #2;
         chk("t6 hold mem_wr_en", 32'(mem_wr_en[1]), 32'd0);
         chk("t6 hold d_done", 32'(d_done[1]), 32'd0);
      end
      cyc_step(); rstn[1] = 1'b1;
      cyc_step();
      if_req[1] = 1'b1; if_addr[1] = 32'h80; d_wr_en[1] = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) cyc_step();
         #2;
         chk($sformatf("t6 if_done c%0d", c), 32'(if_done[1]), 32'(c == 4));
         chk($sformatf("t6 no strobe c%0d", c), 32'(mem_wr_en[1]), 32'd0);
      end
      chk("t6 if_rdata unwritten", if_rdata[1], 32'h1000_0020);
      cyc_step(); if_req[1] = 1'b0;
   endtask

   task automatic rand_drive(input int k, input int n);
      for (int i = 0; i < n; i++) begin
         cyc_step();
         if (!if_req[k] || if_done[k]) if_req[k] = ($urandom_range(0, 3) != 0);
         if (!d_req[k] || d_done[k])   d_req[k]  = ($urandom_range(0, 4) != 0);
         if_addr[k] = {22'd0, 8'($urandom), 2'd0};
         d_addr[k]  = {22'd0, 8'($urandom), 2'd0};
         d_wdata[k] = $urandom;
         d_wr_en[k] = 1'($urandom_range(0, 1));
         d_op[k]    = pick_op($urandom_range(0, 5));
      end
      if_req[k] = 1'b0;
      d_req[k]  = 1'b0;
   endtask

   initial begin
      rstn    = 2'b00;
      if_req  = '0; if_addr = '0;
      d_req   = '0; d_wr_en = '0; d_addr = '0; d_wdata = '0;
      d_op[0] = MEM_W; d_op[1] = MEM_W;
      repeat (3) @(posedge clk);
      #2;
      chk("reset if_rdata L1", if_rdata[0], 32'd0);
      chk("reset d_done L3", 32'(d_done[1]), 32'd0);
      chk("reset mem_op L3", 32'(mem_op[1]), 32'(MEM_W));
      chk("reset mem_wr_en L1", 32'(mem_wr_en[0]), 32'd0);
      rstn = 2'b11;
      directed_l1();
      directed_l3();
      fork
         rand_drive(0, 3000);
         rand_drive(1, 3000);
      join
      repeat (10) cyc_step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
